// File: rtl/lru_array.sv
// lru_array: registered true-LRU rank store for a set-associative cache.
// Each set keeps a WIDTH-bit rank per way (0 = MRU, WAYS-1 = LRU). A touch is
// captured in S1, applied to the array one cycle later, and the resulting
// victim way is reported the cycle after that. A counter sweep loads the
// identity permutation into every set after reset or flush.
module lru_array #(
  parameter int WIDTH    = 3,
  parameter int SETS     = 64,
  parameter int SET_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                req_en,
  output logic                req_rdy,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [WIDTH-1:0]    req_hitA,
  input  logic [WIDTH-1:0]    req_hitB,
  input  logic                req_double,
  output logic                vic_valid,
  output logic [SET_BITS-1:0] vic_set,
  output logic [WIDTH-1:0]    vic_way,
  output logic                init_busy
);

  localparam int WAYS  = 1 << WIDTH;
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;

  typedef enum logic {INIT, READY} state_e;
  typedef logic [WAYS-1:0][WIDTH-1:0] row_t;

  state_e                     state_q, state_d;
  logic [SET_BITS-1:0]        cnt_q, cnt_d;
  row_t [SETS-1:0]            ranks_q, ranks_d;

  logic                       s1_valid_q, s1_valid_d;
  logic [SET_BITS-1:0]        s1_set_q, s1_set_d;
  logic [WIDTH-1:0]           s1_a_q, s1_a_d;
  logic [WIDTH-1:0]           s1_b_q, s1_b_d;
  logic                       s1_dbl_q, s1_dbl_d;

  logic                       vic_valid_q, vic_valid_d;
  logic [SET_BITS-1:0]        vic_set_q, vic_set_d;
  logic [WIDTH-1:0]           vic_way_q, vic_way_d;

  logic                       accept;
  logic [IDX_W-1:0]           s1_idx, cnt_idx;
  row_t                       old_row, new_row;
  logic [WIDTH-1:0]           r_a, r_b, r_w, vic_way_next;
  logic                       dbl_eff;

  assign req_rdy   = (state_q == READY);
  assign init_busy = (state_q == INIT);
  assign vic_valid = vic_valid_q;
  assign vic_set   = vic_set_q;
  assign vic_way   = vic_way_q;

  // Sets at or beyond SETS are dropped at the door so they never index the array.
  assign accept  = req_en && req_rdy && (int'(req_set) < SETS);
  assign s1_idx  = s1_set_q[IDX_W-1:0];
  assign cnt_idx = cnt_q[IDX_W-1:0];

  // Rank update for the set held in S1, plus the way that ends up LRU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    old_row      = ranks_q[s1_idx];
    new_row      = old_row;
    r_w          = '0;
    vic_way_next = '0;
    r_a          = old_row[s1_a_q];
    r_b          = old_row[s1_b_q];
    // A double touch naming the same way twice degenerates to a single touch.
    dbl_eff      = s1_dbl_q && (s1_a_q != s1_b_q);
    for (int w = 0; w < WAYS; w++) begin
      r_w = old_row[w];
      if (WIDTH'(w) == s1_a_q) begin
        new_row[w] = '0;
      end else if (dbl_eff && (WIDTH'(w) == s1_b_q)) begin
        new_row[w] = WIDTH'(1);
      end else begin
        // Ways more recent than a touched way slide one place toward LRU.
        new_row[w] = r_w + WIDTH'(r_w < r_a) + WIDTH'(dbl_eff && (r_w < r_b));
      end
      if (new_row[w] == WIDTH'(WAYS - 1)) vic_way_next = WIDTH'(w);
    end
  end

  // Next-state logic: init sweep, request capture, array write-back, victim.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ranks_d     = ranks_q;
    s1_valid_d  = 1'b0;
    s1_set_d    = s1_set_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_dbl_d    = s1_dbl_q;
    vic_valid_d = 1'b0;
    vic_set_d   = vic_set_q;
    vic_way_d   = vic_way_q;
    case (state_q)
      INIT: begin
        for (int k = 0; k < WAYS; k++) ranks_d[cnt_idx][k] = WIDTH'(k);
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == SET_BITS'(SETS - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_BITS'(1);
        end
      end
      READY: begin
        if (flush) begin
          // In-flight and same-cycle requests are discarded; the sweep rewrites everything.
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          if (accept) begin
            s1_valid_d = 1'b1;
            s1_set_d   = req_set;
            s1_a_d     = req_hitA;
            s1_b_d     = req_hitB;
            s1_dbl_d   = req_double;
          end
          // Write-back lands before the next S1 read, so same-set back-to-back needs no bypass.
          if (s1_valid_q) begin
            ranks_d[s1_idx] = new_row;
            vic_valid_d     = 1'b1;
            vic_set_d       = s1_set_q;
            vic_way_d       = vic_way_next;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_set_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_dbl_q    <= 1'b0;
      vic_valid_q <= 1'b0;
      vic_set_q   <= '0;
      vic_way_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_set_q    <= s1_set_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_dbl_q    <= s1_dbl_d;
      vic_valid_q <= vic_valid_d;
      vic_set_q   <= vic_set_d;
      vic_way_q   <= vic_way_d;
    end
  end

  // Rank storage.
  always_ff @(posedge clk) begin
    // NOTE: the rank array has no reset; the init sweep loads it after every reset or flush.
    ranks_q <= ranks_d;
  end

endmodule

// File: tb/tb_lru_array.sv
// tb_lru_array: scoreboard bench for lru_array with WIDTH=2, SETS=4.
// A move-to-front list model predicts ranks and victims; expected victims are
// queued when a request is driven and popped when vic_valid appears.
module tb_lru_array;

  localparam int WIDTH    = 2;
  localparam int SETS     = 4;
  localparam int SET_BITS = 3;
  localparam int WAYS     = 1 << WIDTH;

  logic                clk;
  logic                rst;
  logic                flush;
  logic                req_en;
  logic                req_rdy;
  logic [SET_BITS-1:0] req_set;
  logic [WIDTH-1:0]    req_hitA;
  logic [WIDTH-1:0]    req_hitB;
  logic                req_double;
  logic                vic_valid;
  logic [SET_BITS-1:0] vic_set;
  logic [WIDTH-1:0]    vic_way;
  logic                init_busy;

  lru_array #(.WIDTH(WIDTH), .SETS(SETS), .SET_BITS(SET_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_en     (req_en),
    .req_rdy    (req_rdy),
    .req_set    (req_set),
    .req_hitA   (req_hitA),
    .req_hitB   (req_hitB),
    .req_double (req_double),
    .vic_valid  (vic_valid),
    .vic_set    (vic_set),
    .vic_way    (vic_way),
    .init_busy  (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int set;
    int way;
  } exp_t;

  exp_t exp_q[$];
  int   model[SETS][WAYS];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) model[s][w] = w;
  endtask

  // Move-to-front on the recency list: A to the front, B right behind it.
  task automatic model_touch(input int s, input int a, input int b, input bit dbl,
                             output int vic);
    int  ord[WAYS];
    int  nord[WAYS];
    int  n;
    bit  two;
    two = dbl && (a != b);
    for (int r = 0; r < WAYS; r++)
      for (int w = 0; w < WAYS; w++)
        if (model[s][w] == r) ord[r] = w;
    nord[0] = a;
    n = 1;
    if (two) begin
      nord[1] = b;
      n = 2;
    end
    for (int r = 0; r < WAYS; r++) begin
      if (ord[r] != a && !(two && ord[r] == b)) begin
        nord[n] = ord[r];
        n++;
      end
    end
    for (int r = 0; r < WAYS; r++) model[s][nord[r]] = r;
    vic = nord[WAYS-1];
  endtask

  // Drive one request for a cycle; queue its expected victim if it will be taken.
  task automatic touch(input int s, input int a, input int b, input bit dbl,
                       input bit scored);
    int vic;
    req_en     = 1'b1;
    req_set    = SET_BITS'(s);
    req_hitA   = WIDTH'(a);
    req_hitB   = WIDTH'(b);
    req_double = dbl;
    if (scored && req_rdy && s < SETS) begin
      model_touch(s, a, b, dbl, vic);
      exp_q.push_back('{s, vic});
    end
    @(posedge clk);
    #1;
    req_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_array(input string tag);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        check($sformatf("%s_s%0d_w%0d", tag, s, w), int'(dut.ranks_q[s][w]), model[s][w]);
  endtask

  // Counts init_busy cycles from the current cycle, bounded.
  task automatic count_init(input string tag);
    int n;
    n = 0;
    while (init_busy && n < 20) begin
      check($sformatf("%s_rdy_low", tag), int'(req_rdy), 0);
      n++;
      @(posedge clk);
      #1;
    end
    check($sformatf("%s_cycles", tag), n, SETS);
    check($sformatf("%s_rdy", tag), int'(req_rdy), 1);
  endtask

  // Scoreboard: every victim report must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && vic_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vic", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("vic_set", int'(vic_set), e.set);
        check("vic_way", int'(vic_way), e.way);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_en     = 1'b0;
    req_set    = '0;
    req_hitA   = '0;
    req_hitB   = '0;
    req_double = 1'b0;
    model_reset();

    // Reset values.
    idle(2);
    check("rst_vic_valid", int'(vic_valid), 0);
    check("rst_vic_set", int'(vic_set), 0);
    check("rst_vic_way", int'(vic_way), 0);
    check("rst_req_rdy", int'(req_rdy), 0);
    check("rst_init_busy", int'(init_busy), 1);
    rst = 1'b0;

    // Init sweep length and contents.
    count_init("init");
    check_array("init");

    // Single touch with explicit latency check: victim only in T+2.
    touch(0, 2, 0, 1'b0, 1'b1);
    check("lat_t1", int'(vic_valid), 0);
    idle(1);
    check("lat_t2", int'(vic_valid), 1);
    idle(1);
    check("lat_t3", int'(vic_valid), 0);

    // Double touch, back-to-back same set, double with A==B, out-of-range set.
    touch(1, 3, 1, 1'b1, 1'b1);
    touch(2, 3, 0, 1'b0, 1'b1);
    touch(2, 0, 0, 1'b0, 1'b1);
    touch(3, 1, 1, 1'b1, 1'b1);
    touch(5, 2, 0, 1'b0, 1'b1);
    touch(7, 1, 3, 1'b1, 1'b1);
    idle(4);
    check_array("directed");

    // Random traffic including out-of-range sets and idle gaps.
    for (int i = 0; i < 60; i++) begin
      touch($urandom_range(0, 5), $urandom_range(0, WAYS-1), $urandom_range(0, WAYS-1),
            1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    check_array("random");
    check("pending_before_flush", exp_q.size(), 0);

    // Flush the cycle after an accepted request: request dropped, sweep reruns.
    touch(3, 2, 0, 1'b0, 1'b0);
    flush  = 1'b1;
    req_en = 1'b1;
    idle(1);
    flush = 1'b0;
    check("flush_vic_valid", int'(vic_valid), 0);
    check("flush_init_busy", int'(init_busy), 1);
    count_init("reinit");
    req_en = 1'b0;
    idle(4);
    model_reset();
    check_array("reinit");

    // Normal operation resumes after the flush.
    touch(0, 1, 2, 1'b1, 1'b1);
    touch(0, 3, 0, 1'b0, 1'b1);
    idle(4);
    check_array("post_flush");
    check("pending_final", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
